// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, widths, command layout
// and the issue FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;
  localparam int SEL_W  = 3;
  localparam int CMD_W  = 2 * OPND_W + SEL_W;

  // Command word layout, LSB first: sel, then b, then a.
  localparam int CMD_SEL_LSB = 0;
  localparam int CMD_B_LSB   = CMD_SEL_LSB + SEL_W;
  localparam int CMD_A_LSB   = CMD_B_LSB + OPND_W;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } issue_state_t;

  // Only add and subtract produce a meaningful carry/borrow in bit 4.
  function automatic logic has_carry_out(input logic [SEL_W-1:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is read
// combinationally so the issue stage can present it without a bubble.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdata = mem[rptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

  // NOTE: storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for a power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding the combinational 4-bit ALU: buffers commands, drives the
// head onto the ALU, captures its result. Optional flags: ALU_ISSUE_FLAGS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic [2:0]             in_sel,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_sel,
  input  logic [4:0]             alu_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_y,
  output logic [2:0]             out_sel,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic                   out_zero,
  output logic                   out_carry
`endif
);

  localparam int CW = CMD_W;

  logic [CW-1:0] cmd_in;
  logic [CW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          has_work;
  alu_cmd_t      head;
  issue_state_t  state;

  assign cmd_in[CMD_A_LSB   +: OPND_W] = in_a;
  assign cmd_in[CMD_B_LSB   +: OPND_W] = in_b;
  assign cmd_in[CMD_SEL_LSB +: SEL_W]  = in_sel;

  // in_ready depends only on occupancy: a pop in the same cycle never frees a full FIFO.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_ISSUE);

  // Work is pending if anything is buffered or arrives on this edge.
  assign has_work = (count != '0) || push;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head    = fifo_empty ? '0 : alu_cmd_t'(fifo_rdata);
  assign alu_a   = head.a;
  assign alu_b   = head.b;
  assign alu_sel = head.sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_sel   <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (has_work) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          out_y     <= alu_y;
          out_sel   <= head.sel;
          out_valid <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
          out_zero  <= (alu_y == '0);
          out_carry <= has_carry_out(head.sel) && alu_y[4];
`endif
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= has_work ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural model of the team ALU
// connected to the alu_* ports; expected results are hand-computed constants.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_y;
  logic [2:0] out_sel;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_ISSUE_FLAGS_EN
  logic       out_zero;
  logic       out_carry;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] y;
    logic [2:0] sel;
  } res_t;

  res_t exp_q[$];

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sel   (out_sel),
    .count     (count)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  // Combinational 4-bit ALU with a 5-bit result.
  always_comb begin
    alu_y = '0;
    unique case (alu_sel)
      OP_ADD: alu_y = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: alu_y = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND: alu_y = {1'b0, alu_a & alu_b};
      OP_OR:  alu_y = {1'b0, alu_a | alu_b};
      OP_XOR: alu_y = {1'b0, alu_a ^ alu_b};
      OP_NOT: alu_y = ~{1'b0, alu_a};
      OP_SHL: alu_y = {alu_a, 1'b0};
      OP_SHR: alu_y = {2'b00, alu_a[3:1]};
      default: alu_y = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_valid = 1'b1;
  endtask

  // Single command through an idle, empty stage with out_ready held high.
  task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic [4:0] y);
    out_ready = 1'b1;
    drive_cmd(a, b, sel);
    step();
    in_valid = 1'b0;
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " alu_sel"}, alu_sel, sel);
    check({tag, " valid low in issue"}, out_valid, 1'b0);
    step();
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " out_y"}, out_y, y);
    check({tag, " out_sel"}, out_sel, sel);
`ifdef ALU_ISSUE_FLAGS_EN
    check({tag, " out_zero"}, out_zero, (y == 5'd0));
    check({tag, " out_carry"}, out_carry, ((sel == OP_ADD) || (sel == OP_SUB)) ? y[4] : 1'b0);
`endif
    step();
    check({tag, " valid cleared"}, out_valid, 1'b0);
  endtask

  // Accept results with out_ready high until exp_q is empty, bounded in cycles.
  task automatic drain(input string tag);
    res_t e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check({tag, " y"}, out_y, e.y);
        check({tag, " sel"}, out_sel, e.sel);
      end
      step();
    end
    check({tag, " results left"}, exp_q.size(), 0);
    check({tag, " count empty"}, count, 0);
    check({tag, " valid idle"}, out_valid, 1'b0);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    out_ready = 1'b0;

    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst count", count, 0);
    check("rst out_y", out_y, 0);
    check("rst out_sel", out_sel, 0);
    check("rst alu_a", alu_a, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("in_ready after reset", in_ready, 1'b1);

    // Single-command latency and operation coverage.
    run_one("add 9+8", 4'd9, 4'd8, OP_ADD, 5'd17);
    run_one("sub 3-5", 4'd3, 4'd5, OP_SUB, 5'd30);
    run_one("not 5", 4'd5, 4'd0, OP_NOT, 5'd26);
    run_one("shl 9", 4'd9, 4'd0, OP_SHL, 5'd18);
    run_one("and 0&0", 4'd0, 4'd0, OP_AND, 5'd0);
    run_one("xor 12^10", 4'd12, 4'd10, OP_XOR, 5'd6);
    run_one("shr 9", 4'd9, 4'd0, OP_SHR, 5'd4);

    // Stall: five accepts fill one HOLD slot plus DEPTH buffered entries.
    out_ready = 1'b0;
    exp_q.push_back('{y: 5'd3,  sel: OP_ADD});
    exp_q.push_back('{y: 5'd4,  sel: OP_SUB});
    exp_q.push_back('{y: 5'd16, sel: OP_ADD});
    exp_q.push_back('{y: 5'd2,  sel: OP_AND});
    exp_q.push_back('{y: 5'd15, sel: OP_OR});
    drive_cmd(4'd1, 4'd2, OP_ADD);  #0 check("stall ready 0", in_ready, 1'b1); step();
    drive_cmd(4'd7, 4'd3, OP_SUB);  #0 check("stall ready 1", in_ready, 1'b1); step();
    drive_cmd(4'd15, 4'd1, OP_ADD); #0 check("stall ready 2", in_ready, 1'b1); step();
    drive_cmd(4'd6, 4'd3, OP_AND);  #0 check("stall ready 3", in_ready, 1'b1); step();
    drive_cmd(4'd10, 4'd5, OP_OR);  #0 check("stall ready 4", in_ready, 1'b1); step();
    check("full count", count, DEPTH);
    check("full in_ready", in_ready, 1'b0);
    check("full out_valid", out_valid, 1'b1);
    // Offered while full; must be refused and never emerge.
    drive_cmd(4'd15, 4'd15, OP_XOR);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stalled out_y stable", out_y, 5'd3);
    end
    in_valid = 1'b0;
    check("full count held", count, DEPTH);
    drain("stall drain");

    // Push while the ISSUE cycle pops, with two entries buffered.
    out_ready = 1'b0;
    drive_cmd(4'd2, 4'd3, OP_ADD); step();
    drive_cmd(4'd8, 4'd8, OP_SUB); step();
    drive_cmd(4'd4, 4'd0, OP_SHR); step();
    in_valid = 1'b0;
    check("pp count before", count, 2);
    check("pp first y", out_y, 5'd5);
    out_ready = 1'b1;
    step();
    check("pp issue count", count, 2);
    check("pp issue valid", out_valid, 1'b0);
    out_ready = 1'b0;
    drive_cmd(4'd3, 4'd0, OP_SHL);
    step();
    in_valid = 1'b0;
    check("pp count after", count, 2);
    check("pp held y", out_y, 5'd0);
    exp_q.push_back('{y: 5'd0, sel: OP_SUB});
    exp_q.push_back('{y: 5'd2, sel: OP_SHR});
    exp_q.push_back('{y: 5'd6, sel: OP_SHL});
    drain("pp drain");

    // Asynchronous reset while holding a result with three commands buffered.
    out_ready = 1'b0;
    drive_cmd(4'd1, 4'd1, OP_ADD); step();
    drive_cmd(4'd2, 4'd2, OP_ADD); step();
    drive_cmd(4'd3, 4'd3, OP_ADD); step();
    drive_cmd(4'd4, 4'd4, OP_ADD); step();
    in_valid = 1'b0;
    check("prerst count", count, 3);
    check("prerst valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", out_valid, 1'b0);
    check("async rst count", count, 0);
    check("async rst alu_a", alu_a, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("no stale result", seen, 0);
    run_one("post rst or", 4'd12, 4'd10, OP_OR, 5'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
